// File: rtl/ulbc128_round_ctrl.sv
// Round sequencer for the iterative uLBC-128 datapath: host handshake, round index,
// round-constant LFSR and load/round/final-round strobes.
module ulbc128_round_ctrl #(
  parameter int          ROUNDS  = 28,
  parameter int          CNT_W   = 5,
  parameter logic [5:0]  RC_INIT = 6'h01
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_in_ready,
  input  logic             i_abort,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic             o_ld_en,
  output logic             o_rnd_en,
  output logic             o_mc_bypass,
  output logic [CNT_W-1:0] o_rnd_idx,
  output logic [5:0]       o_rc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_LAST  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDX_PRELAST = CNT_W'(ROUNDS - 2);
  localparam logic [CNT_W-1:0] IDX_ONE     = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_rnd_idx;
  logic [CNT_W-1:0]   w_rnd_idx_nxt;
  logic [5:0]         r_rc;
  logic [5:0]         w_rc_nxt;

  // x^6 + x^5 + 1 style LFSR, maximal length (63) from any nonzero seed
  function automatic logic [5:0] lfsr_next(input logic [5:0] r);
    return {r[4:0], r[5] ^ r[4]};
  endfunction

  // state, round index and round constant registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rnd_idx <= '0;
      r_rc      <= RC_INIT;
    end else begin
      r_state   <= w_state_nxt;
      r_rnd_idx <= w_rnd_idx_nxt;
      r_rc      <= w_rc_nxt;
    end
  end

  // next-state logic and decoded strobes; abort suppresses the round update in its own cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_rnd_idx_nxt = r_rnd_idx;
    w_rc_nxt      = r_rc;
    o_in_ready    = 1'b0;
    o_out_valid   = 1'b0;
    o_ld_en       = 1'b0;
    o_rnd_en      = 1'b0;
    o_mc_bypass   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        o_ld_en    = i_start;
        if (i_start) begin
          w_state_nxt   = S_ROUND;
          w_rnd_idx_nxt = '0;
          w_rc_nxt      = RC_INIT;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_ROUND: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          o_rnd_en      = 1'b1;
          w_rnd_idx_nxt = r_rnd_idx + IDX_ONE;
          w_rc_nxt      = lfsr_next(r_rc);
          if (r_rnd_idx == IDX_PRELAST) begin
            w_state_nxt = S_LAST;
          end else begin
            w_state_nxt = S_ROUND;
          end
        end
      end
      S_LAST: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          o_rnd_en    = 1'b1;
          o_mc_bypass = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_rnd_idx = r_rnd_idx;
  assign o_rc      = r_rc;

endmodule
